// File: rtl/axis_video_pattern_gen.sv
// -----------------------------------------------------------------------------
// axis_video_pattern_gen
//
// AXI-Stream RGB565 test-pattern source for the VGA output path. Emits frames
// of H_RES x V_RES pixels: TUSER marks pixel (0,0), TLAST marks the last pixel
// of every line. Patterns: 0 colour bars, 1 checkerboard, 2 gradient,
// 3 solid colour. Pattern choice and solid colour are sampled only at a frame
// start, so a frame is never a mix of two patterns.
//
// Optional build macro: AXIS_PATTERN_SCROLL_EN
//   When defined, the x used for colour computation is
//   (x + frame_count[7:0]) mod H_RES, so the patterns scroll 1 px per frame.
//   TUSER/TLAST positions are unaffected. When undefined, patterns are static
//   and no scroll adder exists.
//
// Handshake: a beat transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both 1. While tvalid=1 and tready=0 the payload
// (tdata/tuser/tlast) is held; tvalid only falls after a transfer.
//
// Ports:
//   axi_clk        stream clock, rising edge
//   axi_rstn       asynchronous active-low reset
//   enable         run while high; a low level stops at the next frame end
//   pattern_sel    pattern select (latched at frame start)
//   solid_color    RGB565 colour for pattern 3 (latched at frame start)
//   m_axis_tdata   RGB565 pixel
//   m_axis_tuser   start of frame
//   m_axis_tlast   end of line
//   m_axis_tvalid  beat valid
//   m_axis_tready  sink ready
//   busy           frame in progress
//   frame_count    completed frames, wrapping
//   fsm_state      current FSM state (0 IDLE, 1 RUN) for observation
// -----------------------------------------------------------------------------
module axis_video_pattern_gen #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int CHECK_SHIFT = 4
) (
    input  logic        axi_clk,
    input  logic        axi_rstn,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [0:0]  fsm_state
);

    // Counters are at least 10 bits so the gradient slices are always valid.
    localparam int XW    = ($clog2(H_RES) > 10) ? $clog2(H_RES) : 10;
    localparam int YW    = ($clog2(V_RES) > 10) ? $clog2(V_RES) : 10;
    localparam int BAR_W = H_RES / 8;
    localparam int BW    = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic [1:0]    pat_q;
    logic [15:0]   solid_q;

    logic xfer, last_pix, start, advance, stop;

    // Coordinates / settings of the pixel that will be presented next.
    logic [XW-1:0] ld_x;
    logic [YW-1:0] ld_y;
    logic [BW-1:0] ld_cnt;
    logic [2:0]    ld_idx;
    logic [1:0]    ld_pat;
    logic [15:0]   ld_solid;

    // Colour-space x and bar index (differ from ld_x/ld_idx only when scrolling).
    logic [XW-1:0] x_col;
    logic [2:0]    col_idx;
    logic [15:0]   pix_data;

    assign fsm_state = state;

    assign xfer     = (state == ST_RUN) && m_axis_tvalid && m_axis_tready;
    assign last_pix = (x == X_LAST) && (y == Y_LAST);
    // A new frame starts from IDLE, or back-to-back after the last pixel.
    assign start    = ((state == ST_IDLE) && enable) || (xfer && last_pix && enable);
    assign advance  = xfer && !last_pix;
    assign stop     = xfer && last_pix && !enable;

    always_comb begin
        ld_x     = '0;
        ld_y     = '0;
        ld_cnt   = '0;
        ld_idx   = '0;
        ld_pat   = pattern_sel;
        ld_solid = solid_color;
        if (!start) begin
            ld_pat   = pat_q;
            ld_solid = solid_q;
            if (x == X_LAST) begin
                // Line wrap: x and bar state restart, y steps down.
                ld_y = y + YW'(1);
            end else begin
                ld_x = x + XW'(1);
                ld_y = y;
                if (bar_cnt == BAR_LAST) begin
                    ld_cnt = '0;
                    // Saturate so the last bar absorbs the H_RES % 8 remainder.
                    ld_idx = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
                end else begin
                    ld_cnt = bar_cnt + BW'(1);
                    ld_idx = bar_idx;
                end
            end
        end
    end

`ifdef AXIS_PATTERN_SCROLL_EN
    // scroll_q tracks frame_count[7:0] mod H_RES incrementally, which keeps
    // the wrap to one compare/subtract on x + offset.
    logic [XW-1:0] scroll_q;
    logic [XW-1:0] scroll_nxt;
    logic [XW-1:0] ld_off;
    logic [XW:0]   x_sum;

    always_comb begin
        if (frame_count[7:0] == 8'hFF) begin
            scroll_nxt = '0;
        end else if (scroll_q == X_LAST) begin
            scroll_nxt = '0;
        end else begin
            scroll_nxt = scroll_q + XW'(1);
        end
    end

    // The frame that starts on the last-pixel edge sees the incremented count.
    assign ld_off = (xfer && last_pix) ? scroll_nxt : scroll_q;
    assign x_sum  = {1'b0, ld_x} + {1'b0, ld_off};

    always_comb begin
        if (x_sum >= (XW+1)'(H_RES)) begin
            x_col = XW'(x_sum - (XW+1)'(H_RES));
        end else begin
            x_col = x_sum[XW-1:0];
        end
        col_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_col >= XW'(k * BAR_W)) begin
                col_idx = 3'(k);
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            scroll_q <= '0;
        end else if (xfer && last_pix) begin
            scroll_q <= scroll_nxt;
        end
    end
`else
    assign x_col   = ld_x;
    assign col_idx = ld_idx;
`endif

    always_comb begin
        logic [XW-1:0] x_sh;
        logic [YW-1:0] y_sh;
        x_sh     = x_col >> CHECK_SHIFT;
        y_sh     = ld_y >> CHECK_SHIFT;
        pix_data = 16'h0000;
        case (ld_pat)
            2'd0: begin
                case (col_idx)
                    3'd0:    pix_data = 16'hFFFF; // white
                    3'd1:    pix_data = 16'hFFE0; // yellow
                    3'd2:    pix_data = 16'h07FF; // cyan
                    3'd3:    pix_data = 16'h07E0; // green
                    3'd4:    pix_data = 16'hF81F; // magenta
                    3'd5:    pix_data = 16'hF800; // red
                    3'd6:    pix_data = 16'h001F; // blue
                    default: pix_data = 16'h0000; // black
                endcase
            end
            2'd1:    pix_data = (x_sh[0] ^ y_sh[0]) ? 16'hFFFF : 16'h0000;
            2'd2:    pix_data = {x_col[9:5], ld_y[8:3], x_col[4:0]};
            default: pix_data = ld_solid;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state         <= ST_IDLE;
            x             <= '0;
            y             <= '0;
            bar_cnt       <= '0;
            bar_idx       <= '0;
            pat_q         <= '0;
            solid_q       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            frame_count   <= '0;
        end else begin
            if (start || advance) begin
                state         <= ST_RUN;
                m_axis_tvalid <= 1'b1;
                busy          <= 1'b1;
                x             <= ld_x;
                y             <= ld_y;
                bar_cnt       <= ld_cnt;
                bar_idx       <= ld_idx;
                pat_q         <= ld_pat;
                solid_q       <= ld_solid;
                m_axis_tdata  <= pix_data;
                m_axis_tuser  <= start;
                m_axis_tlast  <= (ld_x == X_LAST);
            end else if (stop) begin
                state         <= ST_IDLE;
                m_axis_tvalid <= 1'b0;
                busy          <= 1'b0;
                m_axis_tuser  <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
            if (xfer && last_pix) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/axis_video_pattern_gen.md
Name: axis_video_pattern_gen

Overview:
- AXI-Stream video source on the AXI side of the VGA output path.
- Generates RGB565 frames of H_RES x V_RES pixels with TUSER on the first pixel of each frame and TLAST on the last pixel of each line.
- Feeds the AXI-Stream-to-VGA bridge that writes the async FIFO.
- Used for bring-up, FIFO/underflow debug and as a fallback source when no framebuffer is present.

Parameters:
H_RES, 640, active pixels per line (>= 8)
V_RES, 480, active lines per frame (>= 1)
CHECK_SHIFT, 4, log2 of checkerboard square size in pixels

Ports:
axi_clk  in  1  stream clock; all logic on rising edge
axi_rstn  in  1  reset, asynchronous, active-low
enable  in  1  level; run while high, stop at frame boundary when low
pattern_sel  in  2  0=colour bars, 1=checkerboard, 2=gradient, 3=solid
solid_color  in  16  RGB565 colour for pattern 3
m_axis  master  axi4s_if  TDATA[15:0], TUSER, TLAST, TVALID out; TREADY in
busy  out  1  high while a frame is in progress
frame_count  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Clock and reset: single clock axi_clk; reset axi_rstn is asynchronous and active-low.
- Reset values: TVALID=0, TDATA=0, TUSER=0, TLAST=0, busy=0, frame_count=0, x=0, y=0, FSM=IDLE.
- Output registers: all outputs are registered and driven straight from flops.
- FSM states:
  - IDLE: TVALID=0. If enable=1, latch pattern_sel and solid_color, load pixel (0,0), set TVALID=1 and busy=1 on the next edge, go to RUN. First beat appears 1 cycle after enable is sampled high.
  - RUN: beat transfers when TVALID and TREADY are both 1. On transfer, x increments. At x=H_RES-1, x wraps to 0 and y increments. The next pixel's TDATA/TUSER/TLAST are loaded in the same edge, so throughput is 1 beat/cycle with TREADY held high.
  - RUN, last pixel: on transfer of (H_RES-1, V_RES-1), frame_count increments.
    - If enable=1: reload (0,0) with the re-latched pattern_sel/solid_color and stay in RUN with no bubble.
    - Else: TVALID=0, busy=0, go to IDLE.
- AXI rules:
  - While TVALID=1 and TREADY=0, TDATA/TUSER/TLAST hold stable.
  - TVALID never drops without a transfer.
  - enable going low mid-frame does not truncate the frame.
  - TREADY=0 stalls indefinitely without loss.
- Sideband flags:
  - TUSER=1 only for (0,0).
  - TLAST=1 when x=H_RES-1, on every line including the last.
- Pattern select is frame-atomic: pattern_sel and solid_color changes take effect only at the next frame start.
- Colour bars:
  - 8 bars of width BAR_W=H_RES/8 (integer division). Bar index counter resets each line and advances when the in-bar counter reaches BAR_W-1.
  - Index saturates at 7, so the last bar absorbs the remainder.
  - Colours: WHITE 0xFFFF, YELLOW 0xFFE0, CYAN 0x07FF, GREEN 0x07E0, MAGENTA 0xF81F, RED 0xF800, BLUE 0x001F, BLACK 0x0000.
- Checkerboard: ((x>>CHECK_SHIFT) ^ (y>>CHECK_SHIFT)) bit0. 1 -> 0xFFFF, 0 -> 0x0000.
- Gradient: TDATA = {x[9:5], y[8:3], x[4:0]}. Counters are at least 10 bits and zero-extended.
- Solid: TDATA = latched solid_color.
- Reset mid-frame: asynchronous clear to reset values. The next frame restarts at (0,0) with TUSER.

Optional Feature:
- Macro: AXIS_PATTERN_SCROLL_EN.
- Defined:
  - The x used for colour computation is (x + frame_count[7:0]) mod H_RES, so bars, checker and gradient scroll 1 px/frame. The wrap is implemented with a compare/subtract, not a divider.
  - TUSER and TLAST positions are unchanged.
- Undefined: static patterns; no scroll adder is instantiated.

Test Plan:
- H_RES=8, V_RES=4, pattern 0, TREADY=1, enable=1 -> 32 beats with TDATA per line FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000; TUSER on beat 0 only; TLAST on beats 7,15,23,31; frame_count=1; beat 32 has TUSER=1 with no gap.
- Random TREADY (50%) over 3 frames -> payload sequence identical to the TREADY=1 run; TDATA/TUSER/TLAST stable during every stall; frame_count=3.
- enable dropped at beat 10 of a frame -> frame completes all 32 beats, then TVALID=0, busy=0 on the cycle after the last transfer; no further TUSER.
- pattern_sel changed 0->3 (solid_color=0x1234) mid-frame -> rest of frame stays bars; next frame all beats 0x1234.
- axi_rstn pulsed low at beat 13 -> TVALID/busy/frame_count go 0 asynchronously; after release with enable=1 the first beat is (0,0) with TUSER=1.
- H_RES=10, pattern 0 -> BAR_W=1; beats 7,8,9 are BLACK 0x0000; TLAST on beat 9.
